gcd_engine: RTL and testbench

Parametrised, self-contained GCD unit. It accepts two unsigned operands through a start/ready handshake and computes their greatest common divisor by repeated subtraction. It returns the result with a one-cycle `done` pulse. It replaces the separate datapath/controller pair with a single block that has a synchronous reset, width parameter, zero-operand handling and an optional step counter.

---
 rtl/gcd_engine.sv | 124 ++++++++++++
 tb/tb_gcd_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD unit with start/ready handshake and done pulse.
// Optional saturating step counter is built when GCD_ENGINE_STEPS_EN is defined.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nx;

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
        end else begin
            state <= state_nx;
            a_r   <= a_nx;
            b_r   <= b_nx;
            res_r <= res_nx;
        end
    end

    // Next-state and datapath: one subtraction or termination per CALC cycle.
    always_comb begin
        state_nx = state;
        a_nx     = a_r;
        b_nx     = b_r;
        res_nx   = res_r;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a_in;
                    b_nx     = b_in;
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (a_r == '0) begin
                    res_nx   = b_r;
                    state_nx = DONE;
                end else if (b_r == '0) begin
                    res_nx   = a_r;
                    state_nx = DONE;
                end else if (a_r == b_r) begin
                    res_nx   = a_r;
                    state_nx = DONE;
                end else if (a_r > b_r) begin
                    a_nx = a_r - b_r;
                end else begin
                    b_nx = b_r - a_r;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign gcd_out = res_r;

`ifdef GCD_ENGINE_STEPS_EN
    logic             load;
    logic             inc;
    logic             fin;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] steps_r;

    assign load = ready && start;
    assign inc  = (state == CALC) && (a_r != '0) && (b_r != '0)
                  && (a_r != b_r);
    assign fin  = (state == CALC) && !inc;

    // Saturating subtraction counter; published when the result is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            steps_r <= '0;
        end else begin
            if (load) begin
                cnt_r <= '0;
            end else if (inc && (cnt_r != '1)) begin
                cnt_r <= cnt_r + WIDTH'(1);
            end
            if (fin) begin
                steps_r <= cnt_r;
            end
        end
    end

    assign steps = steps_r;
`else
    assign steps = '0;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: scoreboard bench for gcd_engine (16-bit and 8-bit instances).
// Expected gcd/steps come from a bench-side subtraction model.
module tb_gcd_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        ready;
    logic        done;
    logic [15:0] gcd_out;
    logic [15:0] steps;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ready8;
    logic        done8;
    logic [7:0]  gcd8;
    logic [7:0]  steps8;

    int n_cmp;
    int n_bad;

    int q_gcd[$];
    int q_n[$];

    gcd_engine #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .ready(ready), .done(done), .gcd_out(gcd_out), .steps(steps)
    );

    gcd_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .ready(ready8), .done(done8), .gcd_out(gcd8), .steps(steps8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int a, input int b,
                                  output int g, output int n);
        n = 0;
        g = 0;
        forever begin
            if (a == 0) begin g = b; break; end
            else if (b == 0) begin g = a; break; end
            else if (a == b) begin g = a; break; end
            else if (a > b) a = a - b;
            else b = b - a;
            n++;
        end
    endfunction

    function automatic int exp_steps(input int n, input int maxv);
`ifdef GCD_ENGINE_STEPS_EN
        return (n > maxv) ? maxv : n;
`else
        return 0 * n * maxv;
`endif
    endfunction

    // Drive one request on the 16-bit engine at the first ready cycle.
    task automatic issue(input int a, input int b);
        int g;
        int n;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        a_in  = 16'(a);
        b_in  = 16'(b);
        start = 1'b1;
        model(a, b, g, n);
        q_gcd.push_back(g);
        q_n.push_back(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after acceptance until done is seen (bounded).
    task automatic wait_done(input int bound, output int edges,
                             output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (edges < bound) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0 || gcd_out !== 16'd0
            || steps !== 16'd0) begin
            n_bad++;
            $display("FAIL reset: ready=%b done=%b gcd=%0d steps=%0d, want 1 0 0 0",
                     ready, done, gcd_out, steps);
        end
        n_cmp++;
        if (ready8 !== 1'b1 || gcd8 !== 8'd0 || steps8 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset8: ready=%b gcd=%0d steps=%0d, want 1 0 0",
                     ready8, gcd8, steps8);
        end
    endtask

    task automatic test_basic;
        int e;
        bit s;
        int g;
        int n;
        int low;
        issue(12, 8);
        low = ready ? 0 : 1;
        wait_done(300, e, s);
        g = q_gcd.pop_front();
        n = q_n.pop_front();
        n_cmp++;
        if (!s || gcd_out !== 16'(g) || steps !== 16'(exp_steps(n, 65535))
            || e != n + 1) begin
            n_bad++;
            $display("FAIL basic: seen=%0b gcd=%0d steps=%0d edges=%0d, want gcd=%0d steps=%0d edges=%0d",
                     s, gcd_out, steps, e, g, exp_steps(n, 65535), n + 1);
        end
        n_cmp++;
        if (low != 1 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ready: low_after_accept=%0d ready_at_done=%b, want 1 0",
                     low, ready);
        end
    endtask

    task automatic test_zero_equal;
        int ta[4] = '{0, 0, 25, 7};
        int tb[4] = '{0, 25, 0, 7};
        int e;
        bit s;
        int g;
        int n;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            wait_done(50, e, s);
            g = q_gcd.pop_front();
            n = q_n.pop_front();
            n_cmp++;
            if (!s || gcd_out !== 16'(g) || steps !== 16'd0 || e != 1) begin
                n_bad++;
                $display("FAIL zero_eq(%0d,%0d): seen=%0b gcd=%0d steps=%0d edges=%0d, want gcd=%0d steps=0 edges=1 (n=%0d)",
                         ta[i], tb[i], s, gcd_out, steps, e, g, n);
            end
        end
    endtask

    task automatic test_worst8;
        int e;
        int g;
        int n;
        bit s;
        model(255, 1, g, n);
        @(negedge clk);
        a8     = 8'd255;
        b8     = 8'd1;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        e = 0;
        s = 1'b0;
        while (e < 400) begin
            @(posedge clk);
            #1;
            e++;
            if (done8) begin
                s = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!s || gcd8 !== 8'(g) || steps8 !== 8'(exp_steps(n, 255))
            || e != 255) begin
            n_bad++;
            $display("FAIL worst8: seen=%0b gcd=%0d steps=%0d edges=%0d, want gcd=%0d steps=%0d edges=255",
                     s, gcd8, steps8, e, g, exp_steps(n, 255));
        end
    endtask

    task automatic test_worst16;
        int e;
        bit s;
        int g;
        int n;
        issue(65535, 1);
        wait_done(70000, e, s);
        g = q_gcd.pop_front();
        n = q_n.pop_front();
        n_cmp++;
        if (!s || gcd_out !== 16'(g) || steps !== 16'(exp_steps(n, 65535))
            || e != n + 1) begin
            n_bad++;
            $display("FAIL worst16: seen=%0b gcd=%0d steps=%0d edges=%0d, want gcd=%0d steps=%0d edges=%0d",
                     s, gcd_out, steps, e, g, exp_steps(n, 65535), n + 1);
        end
    endtask

    task automatic test_busy;
        int e;
        bit s;
        int g;
        int n;
        int g2;
        int n2;
        issue(48, 18);
        a_in  = 16'd5;
        b_in  = 16'd5;
        start = 1'b1;
        wait_done(300, e, s);
        g = q_gcd.pop_front();
        n = q_n.pop_front();
        n_cmp++;
        if (!s || gcd_out !== 16'(g) || e != n + 1) begin
            n_bad++;
            $display("FAIL busy_first: seen=%0b gcd=%0d edges=%0d, want gcd=%0d edges=%0d",
                     s, gcd_out, e, g, n + 1);
        end
        model(5, 5, g2, n2);
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_idle: ready=%b done=%b, want 1 0", ready, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50, e, s);
        n_cmp++;
        if (!s || gcd_out !== 16'(g2) || e != n2 + 1) begin
            n_bad++;
            $display("FAIL busy_second: seen=%0b gcd=%0d edges=%0d, want gcd=%0d edges=%0d",
                     s, gcd_out, e, g2, n2 + 1);
        end
    endtask

    task automatic test_back_to_back;
        int ta[3] = '{100, 17, 1024};
        int tb[3] = '{75, 51, 96};
        int e;
        bit s;
        int g;
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i]);
            wait_done(500, e, s);
            g = q_gcd.pop_front();
            n = q_n.pop_front();
            n_cmp++;
            if (!s || gcd_out !== 16'(g)
                || steps !== 16'(exp_steps(n, 65535)) || e != n + 1) begin
                n_bad++;
                $display("FAIL b2b(%0d,%0d): seen=%0b gcd=%0d steps=%0d edges=%0d, want gcd=%0d steps=%0d edges=%0d",
                         ta[i], tb[i], s, gcd_out, steps, e, g,
                         exp_steps(n, 65535), n + 1);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_pulse%0d: done=%b ready=%b, want 0 1",
                         i, done, ready);
            end
        end
    endtask

    task automatic test_reset_mid_calc;
        int e;
        bit s;
        int g;
        int n;
        int extra;
        issue(60000, 3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_gcd.delete();
        q_n.delete();
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0 || gcd_out !== 16'd0
            || steps !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset: ready=%b done=%b gcd=%0d steps=%0d, want 1 0 0 0",
                     ready, done, gcd_out, steps);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL mid_reset_nodone: done pulses=%0d, want 0", extra);
        end
        issue(9, 6);
        wait_done(50, e, s);
        g = q_gcd.pop_front();
        n = q_n.pop_front();
        n_cmp++;
        if (!s || gcd_out !== 16'(g) || e != n + 1) begin
            n_bad++;
            $display("FAIL mid_reset_after: seen=%0b gcd=%0d edges=%0d, want gcd=%0d edges=%0d",
                     s, gcd_out, e, g, n + 1);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        test_reset();
        test_basic();
        test_zero_equal();
        test_worst8();
        test_busy();
        test_back_to_back();
        test_reset_mid_calc();
        test_worst16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
